// File: rtl/iir_tap_sequencer.sv
// Time-multiplexed direct-form IIR tap sequencer: one shared signed multiplier
// walks the b and a taps of each sample into a wide accumulator, then scales.
module iir_tap_sequencer #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  output logic         cfg_err,
  input  logic         clear_hist,
  output logic         busy,
  output logic         sat
);
  localparam int unsigned ACC_W     = 72;
  localparam int unsigned PROD_W    = 2 * W;
  localparam int unsigned JW        = $clog2(N + 1);
  localparam int unsigned GAIN_ADDR = 2 * N + 1;
  localparam logic [W-1:0] ONE  = W'(1) << FRAC;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC_B, MAC_A, SCALE, OUT} state_e;

  state_e                  state_q, state_d;
  logic [JW-1:0]           j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [W-1:0]     x_q [0:N];
  logic signed [W-1:0]     x_d [0:N];
  logic signed [W-1:0]     y_q [1:N];
  logic signed [W-1:0]     y_d [1:N];
  logic signed [W-1:0]     b_q [0:N];
  logic signed [W-1:0]     b_d [0:N];
  logic signed [W-1:0]     a_q [1:N];
  logic signed [W-1:0]     a_d [1:N];
  logic signed [W-1:0]     gain_q, gain_d;
  logic [W-1:0]            out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;
  logic                    sat_q, sat_d;
  logic                    cfg_err_q, cfg_err_d;

  logic signed [W-1:0]      mul_x, mul_c;
  logic signed [PROD_W-1:0] mac_prod;

  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [W-1:0]      y0;
  logic                     y0_clamp;
  logic signed [PROD_W-1:0] gain_prod, gain_sh;
  logic signed [W-1:0]      g_out;
  logic                     g_clamp;

  // The single tap multiplier shared by every MAC cycle
  assign mac_prod = PROD_W'(mul_x) * PROD_W'(mul_c);

  // Output scaling path: truncate, clamp, apply gain, clamp again
  always_comb begin
    acc_sh    = acc_q >>> FRAC;
    y0_clamp  = !((&acc_sh[ACC_W-1:W-1]) || !(|acc_sh[ACC_W-1:W-1]));
    y0        = y0_clamp ? (acc_sh[ACC_W-1] ? SMIN : SMAX) : acc_sh[W-1:0];
    gain_prod = PROD_W'(y0) * PROD_W'(gain_q);
    gain_sh   = gain_prod >>> FRAC;
    g_clamp   = !((&gain_sh[PROD_W-1:W-1]) || !(|gain_sh[PROD_W-1:W-1]));
    g_out     = g_clamp ? (gain_sh[PROD_W-1] ? SMIN : SMAX) : gain_sh[W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    acc_d      = acc_q;
    x_d        = x_q;
    y_d        = y_q;
    b_d        = b_q;
    a_d        = a_q;
    gain_d     = gain_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    cfg_err_d  = 1'b0;
    mul_x      = '0;
    mul_c      = '0;

    // Register file writes land only while idle; anything else is reported
    if (cfg_we) begin
      if (state_q != IDLE) begin
        cfg_err_d = 1'b1;
      end else if (cfg_addr <= 5'(N)) begin
        b_d[JW'(cfg_addr)] = cfg_wdata;
      end else if (cfg_addr <= 5'(2 * N)) begin
        a_d[JW'(cfg_addr - 5'(N))] = cfg_wdata;
      end else if (cfg_addr == 5'(GAIN_ADDR)) begin
        gain_d = cfg_wdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (clear_hist) begin
          for (int k = 1; k <= int'(N); k++) begin
            x_d[k] = '0;
            y_d[k] = '0;
          end
          sat_d = 1'b0;
        end
        if (in_valid) begin
          x_d[0]  = in_data;
          acc_d   = '0;
          j_d     = '0;
          state_d = MAC_B;
        end
      end
      MAC_B: begin
        mul_x = x_q[j_q];
        mul_c = b_q[j_q];
        acc_d = acc_q + ACC_W'(mac_prod);
        if (j_q == JW'(N)) begin
          j_d     = JW'(1);
          state_d = MAC_A;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      MAC_A: begin
        mul_x = y_q[j_q];
        mul_c = a_q[j_q];
        acc_d = acc_q - ACC_W'(mac_prod);
        if (j_q == JW'(N)) begin
          state_d = SCALE;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      SCALE: begin
        out_data_d = g_out;
        sat_d      = sat_q | y0_clamp | g_clamp;
        for (int k = 2; k <= int'(N); k++) begin
          x_d[k] = x_q[k-1];
          y_d[k] = y_q[k-1];
        end
        x_d[1]  = x_q[0];
        y_d[1]  = y0;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == OUT);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      acc_q       <= '0;
      gain_q      <= ONE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int k = 0; k <= int'(N); k++) begin
        x_q[k] <= '0;
        b_q[k] <= (k == 0) ? ONE : '0;
      end
      for (int k = 1; k <= int'(N); k++) begin
        y_q[k] <= '0;
        a_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      gain_q      <= gain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      sat_q       <= sat_d;
      cfg_err_q   <= cfg_err_d;
      x_q         <= x_d;
      y_q         <= y_d;
      b_q         <= b_d;
      a_q         <= a_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Self-checking bench for iir_tap_sequencer: directed scenarios plus random
// traffic against a queue-based arithmetic model of the filter.
module tb_iir_tap_sequencer;
  localparam int N    = 8;
  localparam int FRAC = 24;
  localparam int ONE  = 1 << FRAC;
  localparam int LAT  = 2 * N + 2;  // edges from acceptance to out_valid high

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_err;
  logic        clear_hist = 1'b0;
  logic        busy;
  logic        sat;

  int n_cmp = 0;
  int n_err = 0;

  iir_tap_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .clear_hist(clear_hist), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  // Reference model: coefficient arrays and history queues (index 0 = newest)
  logic signed [31:0] mb [0:N];
  logic signed [31:0] ma [1:N];
  logic signed [31:0] mg;
  logic signed [31:0] mxq [$];
  logic signed [31:0] myq [$];
  bit                 msat;

  task automatic model_clear();
    mxq.delete();
    myq.delete();
    for (int k = 0; k < N; k++) begin
      mxq.push_back(32'sd0);
      myq.push_back(32'sd0);
    end
    msat = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k <= N; k++) mb[k] = 32'sd0;
    for (int k = 1; k <= N; k++) ma[k] = 32'sd0;
    mb[0] = 32'(ONE);
    mg    = 32'(ONE);
    model_clear();
  endtask

  task automatic model_cfg(input logic [4:0] addr, input logic [31:0] data);
    int ai;
    ai = int'(addr);
    if (ai <= N) mb[ai] = data;
    else if (ai <= 2 * N) ma[ai - N] = data;
    else if (ai == 2 * N + 1) mg = data;
  endtask

  function automatic logic signed [31:0] clip(input logic signed [127:0] v, output bit c);
    c = 1'b0;
    if (v > 128'sd2147483647) begin
      c = 1'b1;
      return 32'sh7FFFFFFF;
    end
    if (v < -128'sd2147483648) begin
      c = 1'b1;
      return 32'sh80000000;
    end
    return v[31:0];
  endfunction

  task automatic model_step(input logic signed [31:0] x, output logic [31:0] o);
    logic signed [127:0] acc;
    logic signed [31:0]  y0;
    bit c1, c2;
    acc = 128'(longint'(mb[0]) * longint'(x));
    for (int j = 1; j <= N; j++) begin
      acc = acc + 128'(longint'(mb[j]) * longint'(mxq[j-1]));
      acc = acc - 128'(longint'(ma[j]) * longint'(myq[j-1]));
    end
    y0 = clip(acc >>> FRAC, c1);
    o  = clip(128'(longint'(y0) * longint'(mg)) >>> FRAC, c2);
    if (c1 || c2) msat = 1'b1;
    mxq.push_front(x);
    void'(mxq.pop_back());
    myq.push_front(y0);
    void'(myq.pop_back());
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; clear_hist = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  task automatic accept(input logic [31:0] x, input bit clr, input bit wr,
                        input logic [4:0] addr, input logic [31:0] data);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = x; clear_hist = clr;
    cfg_we = wr; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    in_valid = 1'b0; clear_hist = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic collect(input int hold, output logic [31:0] y, output logic s, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    y = out_data;
    s = sat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp += 6;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", sat); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_passthrough();
    logic [31:0] y, e;
    logic s;
    int lat;
    accept(32'd1000, 1'b0, 1'b0, 5'd0, 32'd0);
    model_step(32'sd1000, e);
    collect(0, y, s, lat);
    n_cmp += 3;
    if (y !== 32'd1000) begin n_err++; $display("FAIL pass_data: got %0d want 1000", y); end
    if (lat !== LAT) begin n_err++; $display("FAIL pass_latency: got %0d edges want %0d", lat, LAT); end
    if (s !== 1'b0) begin n_err++; $display("FAIL pass_sat: got %b want 0", s); end
  endtask

  task automatic test_fir_tap();
    logic [31:0] y, e;
    logic s;
    int lat;
    logic [31:0] xs [3];
    logic [31:0] want [3];
    xs   = '{32'(ONE), 32'd0, 32'd0};
    want = '{32'(ONE), 32'(ONE), 32'd0};
    cfg_write(5'd1, 32'(ONE));
    for (int i = 0; i < 3; i++) begin
      accept(xs[i], i == 0, 1'b0, 5'd0, 32'd0);
      if (i == 0) model_clear();
      model_step(xs[i], e);
      collect(0, y, s, lat);
      n_cmp++;
      if (y !== want[i]) begin n_err++; $display("FAIL fir_out[%0d]: got %0d want %0d", i, $signed(y), $signed(want[i])); end
    end
  endtask

  task automatic test_recursion();
    logic [31:0] y, e;
    logic s;
    int lat;
    reset_dut();
    cfg_write(5'(N + 1), 32'(-8388608));
    for (int i = 0; i < 4; i++) begin
      accept(i == 0 ? 32'(ONE) : 32'd0, i == 0, 1'b0, 5'd0, 32'd0);
      if (i == 0) model_clear();
      model_step(i == 0 ? 32'(ONE) : 32'sd0, e);
      collect(0, y, s, lat);
      n_cmp++;
      if (y !== 32'(ONE >> i)) begin n_err++; $display("FAIL recur_out[%0d]: got %0d want %0d", i, $signed(y), ONE >> i); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int t;
    accept(32'd5000000, 1'b0, 1'b0, 5'd0, 32'd0);
    model_step(32'sd5000000, e);
    t = 0;
    while (out_valid !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    in_valid = 1'b1; in_data = 32'd777;
    for (int c = 0; c < 10; c++) begin
      n_cmp += 2;
      if (out_data !== e) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %0d want %0d", c, $signed(out_data), $signed(e)); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", c, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL bp_not_accepted: busy=%b want 0", busy); end
  endtask

  task automatic test_saturation();
    logic [31:0] y, e;
    logic s;
    int lat;
    reset_dut();
    cfg_write(5'(2 * N + 1), 32'(2 * ONE));
    accept(32'h7FFFFFFF, 1'b0, 1'b0, 5'd0, 32'd0);
    model_step(32'sh7FFFFFFF, e);
    collect(0, y, s, lat);
    n_cmp += 2;
    if (y !== 32'h7FFFFFFF) begin n_err++; $display("FAIL sat_out: got %h want 7fffffff", y); end
    if (s !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", s); end
    clear_hist = 1'b1;
    @(posedge clk); #1;
    clear_hist = 1'b0;
    model_clear();
    n_cmp++;
    if (sat !== 1'b0) begin n_err++; $display("FAIL sat_clear: got %b want 0", sat); end
  endtask

  task automatic test_faults();
    logic [31:0] y, e, x;
    logic s;
    int lat;
    reset_dut();
    x = $urandom;
    accept(x, 1'b0, 1'b0, 5'd0, 32'd0);
    model_step(x, e);
    repeat (N + 1) begin @(posedge clk); #1; end
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 32'(2 * ONE);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_cmp += 2;
    if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfgerr_pulse: got %b want 1", cfg_err); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL cfgerr_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfgerr_one_cycle: got %b want 0", cfg_err); end
    collect(0, y, s, lat);
    n_cmp++;
    if (y !== e) begin n_err++; $display("FAIL cfgerr_output: got %h want %h", y, e); end
    x = $urandom;
    accept(x, 1'b0, 1'b0, 5'd0, 32'd0);
    model_step(x, e);
    collect(0, y, s, lat);
    n_cmp++;
    if (y !== e) begin n_err++; $display("FAIL cfgerr_coef_kept: got %h want %h", y, e); end
    // Abort a sample part-way through the b taps
    cfg_write(5'(2 * N + 1), 32'(ONE / 2));
    accept(32'd123456, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst = 1'b1;
    model_reset();
    x = $urandom;
    accept(x, 1'b0, 1'b0, 5'd0, 32'd0);
    model_step(x, e);
    collect(0, y, s, lat);
    n_cmp++;
    if (y !== x) begin n_err++; $display("FAIL midrst_passthrough: got %h want %h", y, x); end
  endtask

  task automatic test_random();
    logic [31:0] y, e, x, d;
    logic [4:0] addr;
    logic s;
    bit clr, wr;
    int lat;
    reset_dut();
    for (int j = 0; j <= 2 * N; j++) begin
      d = 32'(int'($urandom_range(0, 8388608)) - 4194304);
      cfg_write(5'(j), d);
    end
    cfg_write(5'(2 * N + 1), 32'($urandom_range(ONE / 2, 3 * ONE / 2)));
    cfg_write(5'd25, 32'($urandom));
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rand_bad_addr_err: got %b want 0", cfg_err); end
    for (int i = 0; i < 40; i++) begin
      x    = $urandom;
      clr  = ($urandom_range(0, 7) == 0);
      wr   = ($urandom_range(0, 3) == 0);
      addr = 5'($urandom_range(0, 2 * N + 3));
      d    = 32'(int'($urandom_range(0, 8388608)) - 4194304);
      accept(x, clr, wr, addr, d);
      if (wr) model_cfg(addr, d);
      if (clr) model_clear();
      model_step(x, e);
      collect($urandom_range(0, 3), y, s, lat);
      n_cmp += 3;
      if (y !== e) begin n_err++; $display("FAIL rand_out[%0d]: got %h want %h", i, y, e); end
      if (s !== msat) begin n_err++; $display("FAIL rand_sat[%0d]: got %b want %b", i, s, msat); end
      if (lat !== LAT) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_at [$];
    reset_dut();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd12345;
    for (int c = 0; c < 65; c++) begin
      if (in_ready === 1'b1) acc_at.push_back(c);
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (out_data !== 32'd12345) begin n_err++; $display("FAIL b2b_data: got %0d want 12345", out_data); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2 * N + 6) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    n_cmp++;
    if (acc_at.size() < 3) begin
      n_err++; $display("FAIL b2b_accepts: got %0d want >=3", acc_at.size());
    end else begin
      n_cmp += 2;
      if (acc_at[1] - acc_at[0] !== 2 * N + 4) begin n_err++; $display("FAIL b2b_period0: got %0d want %0d", acc_at[1] - acc_at[0], 2 * N + 4); end
      if (acc_at[2] - acc_at[1] !== 2 * N + 4) begin n_err++; $display("FAIL b2b_period1: got %0d want %0d", acc_at[2] - acc_at[1], 2 * N + 4); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fir_tap();
    test_recursion();
    test_backpressure();
    test_saturation();
    test_faults();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
